// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: CSR addresses, mstatus bit positions,
// interrupt cause codes and the sequencer state encoding.
`default_nettype none

package trap_sequencer_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
  localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
  localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

  typedef enum logic [2:0] {
    TS_IDLE       = 3'd0,
    TS_SAVE_EPC   = 3'd1,
    TS_SAVE_CAUSE = 3'd2,
    TS_SAVE_TVAL  = 3'd3,
    TS_UPD_STATUS = 3'd4,
    TS_MRET       = 3'd5,
    TS_REDIRECT   = 3'd6
  } ts_state_e;

endpackage

`default_nettype wire

// File: rtl/trap_sequencer_irq_prio_enc.sv
// Fixed-priority interrupt encoder: MEI > MSI > MTI over {MEIP,MTIP,MSIP} & {MEIE,MTIE,MSIE}.
`default_nettype none

module irq_prio_enc
  import trap_sequencer_pkg::*;
(
  input  logic [2:0] pend,
  input  logic [2:0] en,
  output logic       valid,
  output logic [3:0] code
);

  logic [2:0] active;

  always_comb begin
    active = pend & en;
    valid  = |active;
    code   = 4'd0;
    if (active[2])      code = IRQ_CODE_MEI;
    else if (active[0]) code = IRQ_CODE_MSI;
    else if (active[1]) code = IRQ_CODE_MTI;
  end

endmodule

`default_nettype wire

// File: rtl/trap_sequencer.sv
// Trap entry / MRET sequencer: detects at commit, flushes, writes the trap CSRs through the
// shared CSR write port (arbitrated against EX), then issues a one-cycle PC redirect.
`default_nettype none

module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_npc,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [3:0]      exc_code,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_valid,
  input  logic [2:0]      irq_pend,
  input  logic [2:0]      mie_en,
  input  logic [XLEN-1:0] mstatus_q,
  input  logic [XLEN-1:0] mtvec_q,
  input  logic [XLEN-1:0] mepc_q,
  input  logic            ex_csr_we,
  input  logic [11:0]     ex_csr_waddr,
  input  logic [XLEN-1:0] ex_csr_wdata,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            trap_busy
);

  ts_state_e       state, state_next;
  logic [XLEN-1:0] epc_q, cause_q, tval_q;
  logic            is_irq_q;
  logic            is_mret_q;
  logic            irq_valid;
  logic [3:0]      irq_code;
  logic            take_exc, take_irq, take_mret;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] status_trap, status_mret;

  irq_prio_enc u_irq_prio_enc (
    .pend  (irq_pend),
    .en    (mie_en),
    .valid (irq_valid),
    .code  (irq_code)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= TS_IDLE;
      epc_q     <= '0;
      cause_q   <= '0;
      tval_q    <= '0;
      is_irq_q  <= 1'b0;
      is_mret_q <= 1'b0;
    end else begin
      state <= state_next;
      if (take_exc) begin
        epc_q     <= exc_pc;
        cause_q   <= {{(XLEN-4){1'b0}}, exc_code};
        tval_q    <= exc_tval;
        is_irq_q  <= 1'b0;
        is_mret_q <= 1'b0;
      end else if (take_irq) begin
        epc_q     <= commit_npc;
        cause_q   <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
        tval_q    <= '0;
        is_irq_q  <= 1'b1;
        is_mret_q <= 1'b0;
      end else if (take_mret) begin
        is_irq_q  <= 1'b0;
        is_mret_q <= 1'b1;
      end
    end
  end

  always_comb begin
    trap_base   = mtvec_q & ~XLEN'(3);
    status_trap = mstatus_q;
    status_trap[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
    status_trap[MSTATUS_MIE]  = 1'b0;
    status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    status_mret = mstatus_q;
    status_mret[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
    status_mret[MSTATUS_MPIE] = 1'b1;
    status_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  always_comb begin
    state_next     = state;
    take_exc       = 1'b0;
    take_irq       = 1'b0;
    take_mret      = 1'b0;
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    flush          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    trap_busy      = (state != TS_IDLE);

    unique case (state)
      TS_IDLE: begin
        if (exc_valid)                                            take_exc  = 1'b1;
        else if (mstatus_q[MSTATUS_MIE] && commit_valid && irq_valid) take_irq  = 1'b1;
        else if (mret_valid)                                      take_mret = 1'b1;

        if (take_exc || take_irq) begin
          state_next = TS_SAVE_EPC;
        end else if (take_mret) begin
          state_next = TS_MRET;
        end else begin
          // No trap: the EX stage owns the CSR port with zero added latency.
          flush     = 1'b0;
          csr_we    = ex_csr_we;
          csr_waddr = ex_csr_waddr;
          csr_wdata = ex_csr_wdata;
        end
      end
      TS_SAVE_EPC: begin
        csr_we = 1'b1; csr_waddr = CSR_MEPC;    csr_wdata = epc_q;
        state_next = TS_SAVE_CAUSE;
      end
      TS_SAVE_CAUSE: begin
        csr_we = 1'b1; csr_waddr = CSR_MCAUSE;  csr_wdata = cause_q;
        state_next = TS_SAVE_TVAL;
      end
      TS_SAVE_TVAL: begin
        csr_we = 1'b1; csr_waddr = CSR_MTVAL;   csr_wdata = tval_q;
        state_next = TS_UPD_STATUS;
      end
      TS_UPD_STATUS: begin
        csr_we = 1'b1; csr_waddr = CSR_MSTATUS; csr_wdata = status_trap;
        state_next = TS_REDIRECT;
      end
      TS_MRET: begin
        csr_we = 1'b1; csr_waddr = CSR_MSTATUS; csr_wdata = status_mret;
        state_next = TS_REDIRECT;
      end
      TS_REDIRECT: begin
        redirect_valid = 1'b1;
        if (is_mret_q)
          redirect_pc = mepc_q & ~XLEN'(3);
        else if (VECTORED_EN && mtvec_q[1:0] == 2'b01 && is_irq_q)
          redirect_pc = trap_base + (XLEN'(cause_q[3:0]) << 2);
        else
          redirect_pc = trap_base;
        state_next = TS_IDLE;
      end
      default: state_next = TS_IDLE;
    endcase

    // Reset forces every output quiet even while the EX stage is still driving.
    if (!rst_n) begin
      state_next     = TS_IDLE;
      take_exc       = 1'b0;
      take_irq       = 1'b0;
      take_mret      = 1'b0;
      csr_we         = 1'b0;
      csr_waddr      = '0;
      csr_wdata      = '0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      trap_busy      = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus randomized events against
// a transaction-level model (expected CSR write list and redirect target per event).
`default_nettype none

module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        commit_valid, exc_valid, mret_valid, ex_csr_we;
  logic [31:0] commit_npc, exc_pc, exc_tval, mstatus_q, mtvec_q, mepc_q, ex_csr_wdata;
  logic [3:0]  exc_code;
  logic [2:0]  irq_pend, mie_en;
  logic [11:0] ex_csr_waddr;

  logic        csr_we, flush, redirect_valid, trap_busy;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, redirect_pc;
  logic        nv_csr_we, nv_flush, nv_redirect_valid, nv_trap_busy;
  logic [11:0] nv_csr_waddr;
  logic [31:0] nv_csr_wdata, nv_redirect_pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] obs_epc, obs_cause, obs_status, obs_pc, obs_pc_nv;

  always #5 clk = ~clk;

  trap_sequencer #(.XLEN(32), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_npc(commit_npc),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_code(exc_code), .exc_tval(exc_tval),
    .mret_valid(mret_valid), .irq_pend(irq_pend), .mie_en(mie_en), .mstatus_q(mstatus_q),
    .mtvec_q(mtvec_q), .mepc_q(mepc_q), .ex_csr_we(ex_csr_we), .ex_csr_waddr(ex_csr_waddr),
    .ex_csr_wdata(ex_csr_wdata), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_busy(trap_busy)
  );

  trap_sequencer #(.XLEN(32), .VECTORED_EN(1'b0)) dut_nv (
    .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_npc(commit_npc),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_code(exc_code), .exc_tval(exc_tval),
    .mret_valid(mret_valid), .irq_pend(irq_pend), .mie_en(mie_en), .mstatus_q(mstatus_q),
    .mtvec_q(mtvec_q), .mepc_q(mepc_q), .ex_csr_we(ex_csr_we), .ex_csr_waddr(ex_csr_waddr),
    .ex_csr_wdata(ex_csr_wdata), .csr_we(nv_csr_we), .csr_waddr(nv_csr_waddr),
    .csr_wdata(nv_csr_wdata), .flush(nv_flush), .redirect_valid(nv_redirect_valid),
    .redirect_pc(nv_redirect_pc), .trap_busy(nv_trap_busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic quiet();
    commit_valid = 0; exc_valid = 0; mret_valid = 0; irq_pend = 0; mie_en = 0;
    commit_npc = 0; exc_pc = 0; exc_code = 0; exc_tval = 0;
    ex_csr_we = 0; ex_csr_waddr = 0; ex_csr_wdata = 0;
  endtask

  // Everything except the CSR state inputs is don't-care while the sequencer is busy.
  task automatic scramble();
    commit_valid = 1'($urandom); exc_valid = 1'($urandom); mret_valid = 1'($urandom);
    irq_pend = 3'($urandom); mie_en = 3'($urandom);
    commit_npc = $urandom; exc_pc = $urandom; exc_code = 4'($urandom); exc_tval = $urandom;
    ex_csr_we = 1'($urandom); ex_csr_waddr = 12'h7C0; ex_csr_wdata = $urandom;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] trap_status(input logic [31:0] ms);
    return (ms & ~32'h0000_1888) | (ms[3] ? 32'h80 : 32'h0) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] mret_status(input logic [31:0] ms);
    return (ms & ~32'h0000_1888) | (ms[7] ? 32'h8 : 32'h0) | 32'h0000_1880;
  endfunction

  // Applies the inputs currently driven in an IDLE cycle and checks the whole resulting event.
  task automatic run_event(input string tag);
    int          kind;
    int          code;
    logic [2:0]  act;
    logic [31:0] base, exp_pc, exp_pc_nv;
    logic [11:0] exp_addr[$];
    logic [31:0] exp_data[$];
    act  = irq_pend & mie_en;
    base = mtvec_q - (mtvec_q % 4);
    code = 0;
    if (exc_valid) kind = 1;
    else if (mstatus_q[3] && commit_valid && act != 0) kind = 2;
    else if (mret_valid) kind = 3;
    else kind = 0;
    exp_pc = base; exp_pc_nv = base;
    if (kind == 1) begin
      exp_addr = '{12'h341, 12'h342, 12'h343, 12'h300};
      exp_data = '{exc_pc, {28'd0, exc_code}, exc_tval, trap_status(mstatus_q)};
    end else if (kind == 2) begin
      code = act[2] ? 11 : (act[0] ? 3 : 7);
      exp_addr = '{12'h341, 12'h342, 12'h343, 12'h300};
      exp_data = '{commit_npc, 32'h8000_0000 + code, 32'h0, trap_status(mstatus_q)};
      if (mtvec_q % 4 == 1) exp_pc = base + 4 * code;
    end else if (kind == 3) begin
      exp_addr = '{12'h300};
      exp_data = '{mret_status(mstatus_q)};
      exp_pc = mepc_q - (mepc_q % 4); exp_pc_nv = exp_pc;
    end

    @(negedge clk);
    checks++;
    if (flush !== (kind != 0) || trap_busy !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s detect: flush=%b busy=%b rv=%b required flush=%b busy=0 rv=0",
               tag, flush, trap_busy, redirect_valid, kind != 0);
    end
    checks++;
    if (kind == 0) begin
      if (csr_we !== ex_csr_we || csr_waddr !== ex_csr_waddr || csr_wdata !== ex_csr_wdata) begin
        errors++;
        $display("FAIL %s passthrough: got we=%b a=%h d=%h required we=%b a=%h d=%h", tag,
                 csr_we, csr_waddr, csr_wdata, ex_csr_we, ex_csr_waddr, ex_csr_wdata);
      end
      step();
      return;
    end else if (csr_we !== 1'b0) begin
      errors++;
      $display("FAIL %s ex_suppress: csr_we=%b required 0", tag, csr_we);
    end
    step(); scramble();

    for (int i = 0; i < exp_addr.size(); i++) begin
      @(negedge clk);
      checks++;
      if (csr_we !== 1'b1 || csr_waddr !== exp_addr[i] || csr_wdata !== exp_data[i] ||
          flush !== 1'b1 || trap_busy !== 1'b1 || redirect_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s write%0d: got we=%b a=%h d=%h fl=%b bz=%b rv=%b required we=1 a=%h d=%h fl=1 bz=1 rv=0",
                 tag, i, csr_we, csr_waddr, csr_wdata, flush, trap_busy, redirect_valid,
                 exp_addr[i], exp_data[i]);
      end
      if (csr_waddr == 12'h341) obs_epc = csr_wdata;
      if (csr_waddr == 12'h342) obs_cause = csr_wdata;
      if (csr_waddr == 12'h300) obs_status = csr_wdata;
      step(); scramble();
    end

    @(negedge clk);
    obs_pc = redirect_pc; obs_pc_nv = nv_redirect_pc;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== exp_pc || csr_we !== 1'b0 ||
        flush !== 1'b1 || trap_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s redirect: got rv=%b pc=%h we=%b fl=%b bz=%b required rv=1 pc=%h we=0 fl=1 bz=1",
               tag, redirect_valid, redirect_pc, csr_we, flush, trap_busy, exp_pc);
    end
    checks++;
    if (nv_redirect_valid !== 1'b1 || nv_redirect_pc !== exp_pc_nv) begin
      errors++;
      $display("FAIL %s redirect_direct: got rv=%b pc=%h required rv=1 pc=%h",
               tag, nv_redirect_valid, nv_redirect_pc, exp_pc_nv);
    end
    quiet();
    step();
  endtask

  task automatic test_reset();
    quiet();
    rst_n = 0; exc_valid = 1; ex_csr_we = 1; ex_csr_waddr = 12'h123; ex_csr_wdata = 32'hA5A5A5A5;
    mstatus_q = 32'h8; mtvec_q = 32'h200; mepc_q = 32'h0;
    step(); step();
    @(negedge clk);
    checks++;
    if (csr_we !== 0 || csr_waddr !== 0 || csr_wdata !== 0 || flush !== 0 ||
        redirect_valid !== 0 || redirect_pc !== 0 || trap_busy !== 0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b a=%h d=%h fl=%b rv=%b pc=%h bz=%b required all 0",
               csr_we, csr_waddr, csr_wdata, flush, redirect_valid, redirect_pc, trap_busy);
    end
    quiet(); rst_n = 1;
    step();
  endtask

  task automatic test_reset_mid();
    quiet();
    exc_valid = 1; exc_pc = 32'h40; exc_code = 4'd5; exc_tval = 32'h1234;
    step(); quiet(); step();
    @(negedge clk);
    checks++;
    if (csr_we !== 1'b1 || csr_waddr !== 12'h342) begin
      errors++;
      $display("FAIL reset_mid_setup: we=%b a=%h required we=1 a=342", csr_we, csr_waddr);
    end
    rst_n = 0; step(); rst_n = 1;
    @(negedge clk);
    checks++;
    if (trap_busy !== 0 || csr_we !== 0 || flush !== 0 || redirect_valid !== 0) begin
      errors++;
      $display("FAIL reset_mid_idle: bz=%b we=%b fl=%b rv=%b required all 0",
               trap_busy, csr_we, flush, redirect_valid);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (csr_we !== 0 || redirect_valid !== 0 || trap_busy !== 0) begin
        errors++;
        $display("FAIL reset_mid_quiet%0d: we=%b rv=%b bz=%b required 0", i,
                 csr_we, redirect_valid, trap_busy);
      end
    end
    step();
  endtask

  task automatic test_exception();
    quiet();
    mstatus_q = 32'h8; mtvec_q = 32'h200;
    exc_valid = 1; exc_pc = 32'h100; exc_code = 4'd2; exc_tval = 32'hDEADBEEF;
    run_event("exception");
    checks++;
    if (obs_epc !== 32'h100 || obs_cause !== 32'h2 || obs_status !== 32'h1880 || obs_pc !== 32'h200) begin
      errors++;
      $display("FAIL exception_values: epc=%h cause=%h status=%h pc=%h required 100 2 1880 200",
               obs_epc, obs_cause, obs_status, obs_pc);
    end
  endtask

  task automatic test_interrupt_vectored();
    quiet();
    mstatus_q = 32'h8; mtvec_q = 32'h301;
    commit_valid = 1; commit_npc = 32'h44; irq_pend = 3'b110; mie_en = 3'b111;
    run_event("irq_vectored");
    checks++;
    if (obs_cause !== 32'h8000000B || obs_epc !== 32'h44 || obs_pc !== 32'h32C || obs_pc_nv !== 32'h300) begin
      errors++;
      $display("FAIL irq_vectored_values: cause=%h epc=%h pc=%h pc_direct=%h required 8000000b 44 32c 300",
               obs_cause, obs_epc, obs_pc, obs_pc_nv);
    end
  endtask

  task automatic test_interrupt_masked();
    quiet();
    mstatus_q = 32'h0; mtvec_q = 32'h301;
    commit_valid = 1; irq_pend = 3'b111; mie_en = 3'b111;
    ex_csr_we = 1; ex_csr_waddr = 12'h340; ex_csr_wdata = 32'hCAFE0001;
    run_event("irq_mie_off");
    mstatus_q = 32'h8; commit_valid = 0;
    ex_csr_we = 1; ex_csr_waddr = 12'h305; ex_csr_wdata = 32'hCAFE0002;
    run_event("irq_no_commit");
    quiet();
  endtask

  task automatic test_mret();
    quiet();
    mstatus_q = 32'h80; mepc_q = 32'h1002; mtvec_q = 32'h201;
    mret_valid = 1;
    run_event("mret");
    checks++;
    if (obs_status !== 32'h1888 || obs_pc !== 32'h1000) begin
      errors++;
      $display("FAIL mret_values: status=%h pc=%h required 1888 1000", obs_status, obs_pc);
    end
  endtask

  task automatic test_exc_with_ex_write();
    quiet();
    mstatus_q = 32'h8; mtvec_q = 32'h400;
    exc_valid = 1; exc_pc = 32'h88; exc_code = 4'd13; exc_tval = 32'h55;
    ex_csr_we = 1; ex_csr_waddr = 12'h7C0; ex_csr_wdata = 32'h11112222;
    run_event("exc_ex_collide");
  endtask

  task automatic test_back_to_back();
    quiet();
    mstatus_q = 32'h8; mtvec_q = 32'h501;
    exc_valid = 1; exc_pc = 32'h10; exc_code = 4'd11; exc_tval = 32'h0;
    commit_valid = 1; irq_pend = 3'b001; mie_en = 3'b111;
    run_event("b2b_exc");
    commit_valid = 1; commit_npc = 32'h14; irq_pend = 3'b001; mie_en = 3'b111;
    run_event("b2b_irq");
    checks++;
    if (obs_cause !== 32'h80000003 || obs_pc !== 32'h50C) begin
      errors++;
      $display("FAIL b2b_irq_values: cause=%h pc=%h required 80000003 50c", obs_cause, obs_pc);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      quiet();
      mstatus_q = $urandom; mtvec_q = $urandom; mepc_q = $urandom;
      exc_valid = ($urandom_range(0, 3) == 0);
      mret_valid = ($urandom_range(0, 3) == 0);
      commit_valid = 1'($urandom); commit_npc = $urandom;
      irq_pend = 3'($urandom); mie_en = 3'($urandom);
      exc_pc = $urandom; exc_code = 4'($urandom); exc_tval = $urandom;
      ex_csr_we = 1'($urandom); ex_csr_waddr = 12'($urandom); ex_csr_wdata = $urandom;
      run_event("random");
    end
  endtask

  initial begin
    quiet();
    rst_n = 0; mstatus_q = 0; mtvec_q = 0; mepc_q = 0;
    test_reset();
    test_reset_mid();
    test_exception();
    test_interrupt_vectored();
    test_interrupt_masked();
    test_mret();
    test_exc_with_ex_write();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
